div_control: RTL and testbench
==============================

DIV_CONTROL -- requirements
Module: div_control

Interface
REQ-001 Clk  in  1  system clock; all state changes on rising edge.
REQ-002 Reset  in  1  asynchronous, active-low reset.
REQ-003 Run  in  1  active-low start pushbutton.
REQ-004 ClearA_LoadB  in  1  active-low; loads the dividend and clears the remainder.
REQ-005 Din  in  8  switch data: dividend on ClearA_LoadB, divisor on Run.
REQ-006 Aval  out  8  remainder register R[7:0].
REQ-007 Bval  out  8  dividend/quotient register Q.
REQ-008 Busy  out  1  high in Load, Shift and Test.
REQ-009 Done  out  1  high in Hold.
REQ-010 DivZero  out  1  divide-by-zero flag.

Function
REQ-011 The block SHALL perform an 8-bit unsigned restoring division.
  - Internal registers: R (9 bits), Q (8), D (8), iteration count (3).
REQ-012 The FSM SHALL have the states Wait, Load, Shift, Test and Hold.
REQ-013 Wait transitions:
  - Run==0 -> Load.
  - Else ClearA_LoadB==0: Q<=Din, R<=0, DivZero<=0; stay in Wait.
  - Run takes priority when both are low.
REQ-014 Load: D<=Din, R<=0, count<=0; next state is Shift.
REQ-015 Shift: {R,Q}<={R,Q}<<1; next state is Test.
REQ-016 Test:
  - If R>=D: R<=R-D, Q[0]<=1; else Q[0]<=0, R unchanged.
  - count<=count+1.
  - Next state is Hold if count==7, else Shift.
REQ-017 Hold SHALL keep R and Q frozen, return to Wait when Run==1, and otherwise remain in Hold.
REQ-018 Latency: Hold SHALL be entered on the 18th rising edge after the edge that sampled Run==0 in Wait.
REQ-019 ClearA_LoadB SHALL be ignored outside Wait.
REQ-020 Din changes outside the Load cycle (divisor) and outside ClearA_LoadB loads in Wait (dividend) SHALL NOT affect the result.
REQ-021 A new Run after Hold SHALL divide the current quotient Q by the new divisor, so results chain without reloading.
REQ-022 The comparison and subtraction SHALL use 9-bit unsigned arithmetic so that no overflow is possible.
REQ-023 With a zero divisor and no short-circuit, the algorithm SHALL naturally yield Q=8'hFF and R=dividend.

Reset
REQ-024 Reset==0 SHALL immediately force, independent of Clk:
  - state Wait;
  - R, Q, D and count to 0;
  - DivZero=0, Busy=0, Done=0.
REQ-025 A reset mid-operation SHALL abort the division; no partial result is retained.

Configuration
REQ-026 The macro DIVZERO_CHECK_EN SHALL control divide-by-zero detection.
REQ-027 With DIVZERO_CHECK_EN defined and Din==0 in Load:
  - D<=0, R<=Q, Q<=8'hFF, DivZero<=1;
  - next state is Hold, reached on the 2nd edge after Run is sampled.
REQ-028 Without DIVZERO_CHECK_EN, DivZero SHALL be tied to 0 and a zero divisor SHALL run the full 16-cycle sequence with the results of REQ-023.

Structure
REQ-029 The shared package div_pkg SHALL hold:
  - the state enum type;
  - WIDTH=8 and ITER=8.
REQ-030 A sub-module div_datapath SHALL hold R, Q, D, the shifter, the 9-bit subtractor and the comparator.
REQ-031 div_datapath SHALL be driven by one-hot load/shift/test strobes from the FSM in div_control.

Verification
REQ-032 Dividend 100 and divisor 7, Run pulse -> Hold at edge 18; Bval=14, Aval=2, Done=1, Busy=0.
REQ-033 255/1 -> Bval=255, Aval=0; 5/9 -> Bval=0, Aval=5.
REQ-034 Dividend 200 and divisor 0:
  - with DIVZERO_CHECK_EN: Hold at edge 2, Bval=255, Aval=200, DivZero=1;
  - without it: Hold at edge 18, same Bval and Aval, DivZero=0.
REQ-035 Reset pulled low during the 4th Test cycle -> same-cycle Wait, Aval=0, Bval=0, Busy=0; a subsequent 100/7 run gives 14 r2.
REQ-036 Handshake and chaining:
  - Run held low 10 cycles after Hold -> stays in Hold with values frozen;
  - ClearA_LoadB pulsed while Busy -> Bval unaffected;
  - release, then Run with divisor 3 on quotient 14 -> Bval=4, Aval=2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the restoring divider: state encoding, operand
// width and iteration count.
package div_pkg;

  localparam int WIDTH = 8;
  localparam int ITER  = 8;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TEST  = 3'd3,
    S_HOLD  = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: remainder R (WIDTH+1 bits), quotient/dividend Q,
// divisor D, the {R,Q} shifter and the 9-bit compare/subtract.
module div_datapath
  import div_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             load_dividend,
  input  logic             load_divisor,
  input  logic             zero_load,
  input  logic             shift_en,
  input  logic             test_en,
  output logic [WIDTH-1:0] r_val,
  output logic [WIDTH-1:0] q_val
);

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   diff;
  logic             r_ge_d;

  // The extra top bit keeps R << 1 and R - D exact, so no overflow is possible.
  assign d_ext  = {1'b0, d};
  assign diff   = r - d_ext;
  assign r_ge_d = (r >= d_ext);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, as the hardware does.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r <= '0;
      q <= '0;
      d <= '0;
    end else if (load_dividend) begin
      q <= Din;
      r <= '0;
    end else if (load_divisor) begin
      d <= Din;
      r <= '0;
    end else if (zero_load) begin
      d <= '0;
      r <= {1'b0, q};
      q <= '1;
    end else if (shift_en) begin
      r <= {r[WIDTH-1:0], q[WIDTH-1]};
      q <= {q[WIDTH-2:0], 1'b0};
    end else if (test_en) begin
      if (r_ge_d) begin
        r    <= diff;
        q[0] <= 1'b1;
      end else begin
        q[0] <= 1'b0;
      end
    end
  end

  assign r_val = r[WIDTH-1:0];
  assign q_val = q;

endmodule

// File: rtl/div_control.sv
// Top of the 8-bit restoring divider: Wait/Load/Shift/Test/Hold FSM driving
// div_datapath with one-hot strobes. Define DIVZERO_CHECK_EN to short-circuit
// a zero divisor straight to Hold with the DivZero flag raised.
module div_control
  import div_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam logic [2:0] ST_WAIT  = S_WAIT;
  localparam logic [2:0] ST_LOAD  = S_LOAD;
  localparam logic [2:0] ST_SHIFT = S_SHIFT;
  localparam logic [2:0] ST_TEST  = S_TEST;
  localparam logic [2:0] ST_HOLD  = S_HOLD;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] count;
  logic             last_iter;
  logic             din_zero;
  logic             load_dividend;
  logic             load_divisor;
  logic             zero_load;
  logic             shift_en;
  logic             test_en;

`ifdef DIVZERO_CHECK_EN
  assign din_zero = (Din == '0);
`else
  assign din_zero = 1'b0;
`endif

  // Run has priority over ClearA_LoadB in Wait; the load is ignored elsewhere.
  assign load_dividend = (state == ST_WAIT) && Run && !ClearA_LoadB;
  assign load_divisor  = (state == ST_LOAD) && !din_zero;
  assign zero_load     = (state == ST_LOAD) && din_zero;
  assign shift_en      = (state == ST_SHIFT);
  assign test_en       = (state == ST_TEST);
  assign last_iter     = (count == CNT_W'(ITER - 1));

  // NOTE: next-state defaults to the current state before the case so no
  // path through the block leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT:  if (!Run) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = din_zero ? ST_HOLD : ST_SHIFT;
      ST_SHIFT: state_nxt = ST_TEST;
      ST_TEST:  state_nxt = last_iter ? ST_HOLD : ST_SHIFT;
      ST_HOLD:  if (Run) state_nxt = ST_WAIT;
      default:  state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_WAIT;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (load_divisor || zero_load)
        count <= '0;
      else if (test_en)
        count <= count + 1'b1;
    end
  end

`ifdef DIVZERO_CHECK_EN
  // Sticky until the next dividend load so software can read it after Hold.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      DivZero <= 1'b0;
    else if (load_dividend)
      DivZero <= 1'b0;
    else if (zero_load)
      DivZero <= 1'b1;
  end
`else
  assign DivZero = 1'b0;
`endif

  assign Busy = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_TEST);
  assign Done = (state == ST_HOLD);

  div_datapath u_datapath (
    .Clk           (Clk),
    .Reset         (Reset),
    .Din           (Din),
    .load_dividend (load_dividend),
    .load_divisor  (load_divisor),
    .zero_load     (zero_load),
    .shift_en      (shift_en),
    .test_en       (test_en),
    .r_val         (Aval),
    .q_val         (Bval)
  );

endmodule

// File: tb/tb_div_control.sv
// Scoreboard bench for div_control: directed divisions push expected results,
// a negedge monitor checks them when Done rises.
module tb_div_control;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] Din;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  div_control dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .Din          (Din),
    .Aval         (Aval),
    .Bval         (Bval),
    .Busy         (Busy),
    .Done         (Done),
    .DivZero      (DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pushes      = 0;
  int   pops        = 0;
  int   cyc         = 0;
  int   start_cyc   = 0;
  logic done_q      = 1'b0;

`ifdef DIVZERO_CHECK_EN
  localparam logic DZ_FLAG = 1'b1;
  localparam int   DZ_LAT  = 2;
`else
  localparam logic DZ_FLAG = 1'b0;
  localparam int   DZ_LAT  = 18;
`endif

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per rising Done; latency counts the edge
  // that samples Run low as edge 1.
  always @(negedge Clk) begin
    exp_t e;
    if (Done && !done_q) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got Done=1, required no pending result");
      end else begin
        e = sb.pop_front();
        check({e.name, "_quotient"}, Bval, e.q);
        check({e.name, "_remainder"}, Aval, e.r);
        check({e.name, "_divzero"}, DivZero, e.dz);
        check({e.name, "_busy"}, Busy, 0);
        check({e.name, "_latency"}, cyc - start_cyc, e.lat);
        pops++;
      end
    end
    done_q = Done;
  end

  task automatic load_dividend(input logic [7:0] v);
    @(negedge Clk);
    Din          = v;
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    Din          = 8'hC3;
  endtask

  task automatic run_div(input string name, input logic [7:0] divisor,
                         input logic [7:0] q, input logic [7:0] r,
                         input logic dz, input int lat,
                         input bit hold_run, input bit poke_clr);
    @(negedge Clk);
    Din       = divisor;
    Run       = 1'b0;
    start_cyc = cyc;
    sb.push_back('{name, q, r, dz, lat});
    pushes++;
    @(negedge Clk);
    if (!hold_run) Run = 1'b1;
    @(negedge Clk);
    Din = ~divisor;
    if (poke_clr) begin
      @(negedge Clk);
      check({name, "_busy_mid"}, Busy, 1);
      Din          = 8'h5A;
      ClearA_LoadB = 1'b0;
      @(negedge Clk);
      ClearA_LoadB = 1'b1;
    end
    for (int i = 0; i < 60 && pops < pushes; i++) @(negedge Clk);
    check({name, "_completed"}, pops, pushes);
  endtask

  initial begin
    Reset        = 1'b0;
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    Din          = 8'h00;
    #12;
    check("rst_aval", Aval, 0);
    check("rst_bval", Bval, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_divzero", DivZero, 0);
    @(negedge Clk);
    Reset = 1'b1;

    load_dividend(8'd100);
    run_div("div_100_7", 8'd7, 8'd14, 8'd2, 1'b0, 18, 1'b0, 1'b0);
    load_dividend(8'd255);
    run_div("div_255_1", 8'd1, 8'd255, 8'd0, 1'b0, 18, 1'b0, 1'b0);
    load_dividend(8'd5);
    run_div("div_5_9", 8'd9, 8'd0, 8'd5, 1'b0, 18, 1'b0, 1'b0);
    load_dividend(8'd200);
    run_div("div_200_0", 8'd0, 8'd255, 8'd200, DZ_FLAG, DZ_LAT, 1'b0, 1'b0);

    // Abort: reset during the 4th Test cycle (entered on edge 9).
    load_dividend(8'd100);
    @(negedge Clk);
    Din = 8'd7;
    Run = 1'b0;
    @(negedge Clk);
    Run = 1'b1;
    repeat (8) @(negedge Clk);
    check("abort_busy_before", Busy, 1);
    Reset = 1'b0;
    #1;
    check("abort_aval", Aval, 0);
    check("abort_bval", Bval, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    @(negedge Clk);
    Reset = 1'b1;
    load_dividend(8'd100);
    run_div("after_abort", 8'd7, 8'd14, 8'd2, 1'b0, 18, 1'b0, 1'b0);

    // Handshake: Run held low through Hold, ClearA_LoadB poked while busy and in Hold.
    load_dividend(8'd100);
    run_div("hold_run", 8'd7, 8'd14, 8'd2, 1'b0, 18, 1'b1, 1'b1);
    repeat (4) @(negedge Clk);
    Din          = 8'h37;
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    repeat (5) @(negedge Clk);
    check("hold_done", Done, 1);
    check("hold_bval", Bval, 14);
    check("hold_aval", Aval, 2);
    check("hold_busy", Busy, 0);
    Run = 1'b1;
    @(negedge Clk);
    check("hold_released", Done, 0);
    run_div("chain_14_3", 8'd3, 8'd4, 8'd2, 1'b0, 18, 1'b0, 1'b0);

    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
